// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one request outstanding on the
// instruction SRAM-like bus, and drives the IF/ID pipeline register.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        flush,
   input  logic [31:0] new_pc,
   input  logic [32:0] br_bus,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [32:0] if_to_id_bus,
   output logic [31:0] inst
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] pc_reg, pc_next;
   logic [31:0] req_pc_reg, req_pc_next;
   logic        redir_v_reg, redir_v_next;
   logic [31:0] redir_pc_reg, redir_pc_next;
   logic        cancel_reg, cancel_next;
   logic [31:0] hold_pc_reg, hold_pc_next;
   logic [31:0] hold_inst_reg, hold_inst_next;
   logic [32:0] out_bus_reg, out_bus_next;
   logic [31:0] out_inst_reg, out_inst_next;

   logic        br_e;
   logic [31:0] br_addr;
   logic        handshake;
   logic        avail;
   logic        deliver;
   logic [31:0] dlv_pc;
   logic [31:0] dlv_inst;
   logic        unused_stall;

   // Only the PC, IF/ID and ID stall bits matter to this stage.
   assign unused_stall = &{1'b0, stall[5:3]};

   assign br_e      = br_bus[32];
   assign br_addr   = br_bus[31:0];
   assign inst_req  = (state_reg == S_REQ) && !stall[0];
   assign inst_addr = pc_reg;
   assign handshake = inst_req && inst_addr_ok;
   assign avail     = ((state_reg == S_WAIT) && inst_data_ok && !cancel_reg)
                    || (state_reg == S_HOLD);
   assign dlv_pc    = (state_reg == S_HOLD) ? hold_pc_reg : req_pc_reg;
   assign dlv_inst  = (state_reg == S_HOLD) ? hold_inst_reg : inst_rdata;
   assign deliver   = avail && !stall[1] && !flush;

   assign if_to_id_bus = out_bus_reg;
   assign inst         = out_inst_reg;

   always_comb begin
      state_next     = state_reg;
      req_pc_next    = req_pc_reg;
      cancel_next    = cancel_reg;
      hold_pc_next   = hold_pc_reg;
      hold_inst_next = hold_inst_reg;

      case (state_reg)
         S_REQ: begin
            if (handshake) begin
               req_pc_next = pc_reg;
               state_next  = S_WAIT;
               if (flush) begin
                  cancel_next = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (inst_data_ok) begin
               if (flush || cancel_reg) begin
                  state_next  = S_REQ;
                  cancel_next = 1'b0;
               end else if (!stall[1]) begin
                  state_next = S_REQ;
               end else begin
                  state_next     = S_HOLD;
                  hold_pc_next   = req_pc_reg;
                  hold_inst_next = inst_rdata;
               end
            end else if (flush) begin
               cancel_next = 1'b1;
            end
         end
         S_HOLD: begin
            if (flush || !stall[1]) begin
               state_next = S_REQ;
            end
         end
         default: begin
            state_next = S_REQ;
         end
      endcase
   end

   // A branch seen in the same cycle as a delivery leaves that delivery alone and
   // redirects the one after it; the delivery consumes only an already-pending redirect.
   always_comb begin
      pc_next       = pc_reg;
      redir_v_next  = redir_v_reg;
      redir_pc_next = redir_pc_reg;

      if (flush) begin
         pc_next      = new_pc;
         redir_v_next = 1'b0;
      end else begin
         if (deliver) begin
            pc_next      = redir_v_reg ? redir_pc_reg : dlv_pc + 32'd4;
            redir_v_next = 1'b0;
         end
         if (br_e) begin
            redir_v_next  = 1'b1;
            redir_pc_next = br_addr;
         end
      end
   end

   always_comb begin
      out_bus_next  = out_bus_reg;
      out_inst_next = out_inst_reg;

      if (flush) begin
         out_bus_next  = '0;
         out_inst_next = '0;
      end else if (!stall[1]) begin
         out_bus_next  = avail ? {1'b1, dlv_pc} : 33'd0;
         out_inst_next = avail ? dlv_inst : 32'd0;
      end else if (!stall[2]) begin
         out_bus_next  = '0;
         out_inst_next = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= S_REQ;
         pc_reg        <= RESET_PC;
         req_pc_reg    <= '0;
         redir_v_reg   <= 1'b0;
         redir_pc_reg  <= '0;
         cancel_reg    <= 1'b0;
         hold_pc_reg   <= '0;
         hold_inst_reg <= '0;
         out_bus_reg   <= '0;
         out_inst_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         pc_reg        <= pc_next;
         req_pc_reg    <= req_pc_next;
         redir_v_reg   <= redir_v_next;
         redir_pc_reg  <= redir_pc_next;
         cancel_reg    <= cancel_next;
         hold_pc_reg   <= hold_pc_next;
         hold_inst_reg <= hold_inst_next;
         out_bus_reg   <= out_bus_next;
         out_inst_reg  <= out_inst_next;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: a directed cycle table for the fetch corner cases, then random
// traffic against a stream-level model of which PC must be delivered next.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  stall = '0;
   logic        flush = 1'b0;
   logic [31:0] new_pc = '0;
   logic [32:0] br_bus = '0;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok = 1'b0;
   logic        inst_data_ok = 1'b0;
   logic [31:0] inst_rdata = '0;
   logic [32:0] if_to_id_bus;
   logic [31:0] inst;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .flush       (flush),
      .new_pc      (new_pc),
      .br_bus      (br_bus),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok),
      .inst_rdata  (inst_rdata),
      .if_to_id_bus(if_to_id_bus),
      .inst        (inst)
   );

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] new_pc;
      logic        br_e;
      logic [31:0] br_addr;
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] rdata;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [32:0] exp_bus;
      logic [31:0] exp_inst;
   } vec_t;

   vec_t vecs [24];

   task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
      n_total++;
      if (got !== exp) begin
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   logic        accept;
   logic [31:0] acc_addr;
   logic [32:0] prev_bus;
   logic [31:0] prev_inst;
   logic        cur_br_e;
   logic [31:0] exp_pc;
   logic        m_redir_v;
   logic [31:0] m_redir_pc;
   logic        mem_pend;
   logic [31:0] mem_addr;
   int          mem_dly;
   int          deliveries;

   initial begin
      //          stall  fl  new_pc        br  br_addr       aok dok rdata         req addr          bus                 inst
      vecs[0]  = '{6'h00, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC0_0000, 33'h0,             32'h0};
      vecs[1]  = '{6'h00, 0, 32'h0,        0, 32'h0,        0, 1, 32'h3C01_1234, 0, 32'hBFC0_0000, 33'h1_BFC0_0000,   32'h3C01_1234};
      vecs[2]  = '{6'h00, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC0_0004, 33'h0,             32'h0};
      vecs[3]  = '{6'h06, 0, 32'h0,        0, 32'h0,        0, 1, 32'h2421_0001, 0, 32'hBFC0_0004, 33'h0,             32'h0};
      vecs[4]  = '{6'h06, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'hBFC0_0004, 33'h0,             32'h0};
      vecs[5]  = '{6'h06, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 32'hBFC0_0004, 33'h0,             32'h0};
      vecs[6]  = '{6'h00, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC0_0004, 33'h1_BFC0_0004,   32'h2421_0001};
      vecs[7]  = '{6'h00, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC0_0008, 33'h0,             32'h0};
      vecs[8]  = '{6'h00, 0, 32'h0,        1, 32'hBFC0_0100, 0, 0, 32'h0,       0, 32'hBFC0_0008, 33'h0,             32'h0};
      vecs[9]  = '{6'h00, 0, 32'h0,        0, 32'h0,        0, 1, 32'h8C22_0000, 0, 32'hBFC0_0008, 33'h1_BFC0_0008,   32'h8C22_0000};
      vecs[10] = '{6'h00, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC0_0100, 33'h0,             32'h0};
      vecs[11] = '{6'h00, 1, 32'hBFC0_0380, 0, 32'h0,       0, 0, 32'h0,        0, 32'hBFC0_0100, 33'h0,             32'h0};
      vecs[12] = '{6'h00, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC0_0380, 33'h0,             32'h0};
      vecs[13] = '{6'h00, 0, 32'h0,        0, 32'h0,        0, 1, 32'hDEAD_BEEF, 0, 32'hBFC0_0380, 33'h0,             32'h0};
      vecs[14] = '{6'h00, 1, 32'hBFC0_0380, 0, 32'h0,       1, 0, 32'h0,        1, 32'hBFC0_0380, 33'h0,             32'h0};
      vecs[15] = '{6'h00, 0, 32'h0,        0, 32'h0,        0, 1, 32'hBAAD_F00D, 0, 32'hBFC0_0380, 33'h0,             32'h0};
      vecs[16] = '{6'h00, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hBFC0_0380, 33'h0,             32'h0};
      vecs[17] = '{6'h00, 0, 32'h0,        0, 32'h0,        0, 1, 32'h4080_6000, 0, 32'hBFC0_0380, 33'h1_BFC0_0380,   32'h4080_6000};
      vecs[18] = '{6'h00, 1, 32'hFFFF_FFFC, 1, 32'h1234_5678, 0, 0, 32'h0,      1, 32'hBFC0_0384, 33'h0,             32'h0};
      vecs[19] = '{6'h00, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 32'hFFFF_FFFC, 33'h0,             32'h0};
      vecs[20] = '{6'h00, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1111_1111, 0, 32'hFFFF_FFFC, 33'h1_FFFF_FFFC,   32'h1111_1111};
      vecs[21] = '{6'h06, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0000, 33'h1_FFFF_FFFC,   32'h1111_1111};
      vecs[22] = '{6'h02, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h0000_0000, 33'h0,             32'h0};
      vecs[23] = '{6'h01, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 32'h0000_0000, 33'h0,             32'h0};

      // Reset state.
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("reset_req", 96'(inst_req), 96'(1'b1));
      chk("reset_addr", 96'(inst_addr), 96'(RESET_PC));
      chk("reset_bus", 96'(if_to_id_bus), 96'(33'd0));
      chk("reset_inst", 96'(inst), 96'(32'd0));
      rst = 1'b0;

      // Directed cycle table.
      for (int i = 0; i < 24; i++) begin
         stall        = vecs[i].stall;
         flush        = vecs[i].flush;
         new_pc       = vecs[i].new_pc;
         br_bus       = {vecs[i].br_e, vecs[i].br_addr};
         inst_addr_ok = vecs[i].addr_ok;
         inst_data_ok = vecs[i].data_ok;
         inst_rdata   = vecs[i].rdata;
         #1;
         chk($sformatf("row%0d_req", i), 96'(inst_req), 96'(vecs[i].exp_req));
         chk($sformatf("row%0d_addr", i), 96'(inst_addr), 96'(vecs[i].exp_addr));
         @(posedge clk);
         #1;
         chk($sformatf("row%0d_bus", i), 96'(if_to_id_bus), 96'(vecs[i].exp_bus));
         chk($sformatf("row%0d_inst", i), 96'(inst), 96'(vecs[i].exp_inst));
         $display("row %0d: req=%b addr=%h bus=%h inst=%h", i, inst_req, inst_addr,
                  if_to_id_bus, inst);
      end

      // Reset mid-operation, memory side reset along with the block.
      stall        = '0;
      flush        = 1'b0;
      br_bus       = '0;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      rst          = 1'b1;
      #1;
      chk("midreset_addr", 96'(inst_addr), 96'(RESET_PC));
      chk("midreset_bus", 96'(if_to_id_bus), 96'(33'd0));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      exp_pc     = RESET_PC;
      m_redir_v  = 1'b0;
      m_redir_pc = '0;
      mem_pend   = 1'b0;
      mem_addr   = '0;
      mem_dly    = 0;
      deliveries = 0;

      // Randomized traffic against the stream model.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         stall[0]     = ($urandom_range(0, 4) == 0);
         stall[1]     = ($urandom_range(0, 4) == 0);
         stall[2]     = 1'($urandom_range(0, 1));
         stall[5:3]   = 3'($urandom);
         flush        = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 7))
            0:       new_pc = 32'hFFFF_FFFC;
            1:       new_pc = 32'hFFFF_FFF8;
            default: new_pc = $urandom & 32'hFFFF_FFFC;
         endcase
         cur_br_e     = ($urandom_range(0, 9) == 0);
         br_bus       = {cur_br_e, $urandom & 32'hFFFF_FFFC};
         inst_addr_ok = ($urandom_range(0, 3) != 0);
         inst_data_ok = mem_pend && (mem_dly == 0);
         inst_rdata   = inst_data_ok ? mem_word(mem_addr) : $urandom;
         #1;
         accept   = inst_req && inst_addr_ok;
         acc_addr = inst_addr;
         if (mem_pend) begin
            chk("one_outstanding", 96'(inst_req), 96'(1'b0));
         end
         if (accept) begin
            chk("fetch_addr", 96'(inst_addr), 96'(exp_pc));
         end
         prev_bus  = if_to_id_bus;
         prev_inst = inst;
         @(posedge clk);
         #1;

         if (inst_data_ok) begin
            mem_pend = 1'b0;
         end else if (mem_pend) begin
            mem_dly--;
         end
         if (accept) begin
            mem_pend = 1'b1;
            mem_addr = acc_addr;
            mem_dly  = $urandom_range(0, 2);
         end

         if (flush) begin
            chk("flush_bubble", {if_to_id_bus, inst}, 96'd0);
            exp_pc    = new_pc;
            m_redir_v = 1'b0;
         end else begin
            if (!stall[1]) begin
               if (if_to_id_bus[32]) begin
                  deliveries++;
                  chk("deliver_pc", 96'(if_to_id_bus[31:0]), 96'(exp_pc));
                  chk("deliver_inst", 96'(inst), 96'(mem_word(exp_pc)));
                  $display("deliver %0d: pc=%h inst=%h", deliveries, if_to_id_bus[31:0], inst);
                  exp_pc    = m_redir_v ? m_redir_pc : exp_pc + 32'd4;
                  m_redir_v = 1'b0;
               end else begin
                  chk("bubble_zero", {if_to_id_bus, inst}, 96'd0);
               end
            end else if (!stall[2]) begin
               chk("stall_bubble", {if_to_id_bus, inst}, 96'd0);
            end else begin
               chk("stall_hold", {if_to_id_bus, inst}, {prev_bus, prev_inst});
            end
            if (cur_br_e) begin
               m_redir_v  = 1'b1;
               m_redir_pc = br_bus[31:0];
            end
         end
      end
      chk("liveness", 96'(deliveries >= 100), 96'(1'b1));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
